// File: rtl/bfp_acc_normalizer.sv
// Block-floating-point group-sum accumulator with bfloat16 normalization.
// Optional macro FMAC_RNE_EN selects round-to-nearest-even (default: truncate).
module bfp_acc_normalizer #(
    parameter int unsigned GRPSIZE       = 16,
    parameter int unsigned MULBFPMANSIZE = 6,
    parameter int unsigned LEVELS        = $clog2(GRPSIZE),
    parameter int unsigned BFPEXPSIZE    = 8,
    parameter int unsigned ACCSIZE       = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_sign,
    input  logic [MULBFPMANSIZE+LEVELS-1:0] i_man,
    input  logic [BFPEXPSIZE:0]             i_exp,
    input  logic                            i_last,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [15:0]                     o_data
);

    localparam int unsigned EW = BFPEXPSIZE + 1;
    localparam int unsigned PW = $clog2(ACCSIZE);
    localparam int unsigned XW = BFPEXPSIZE + 8;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_NORM, S_OUT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ready;
    logic                  r_valid;
    logic                  w_ready_nxt;
    logic                  w_valid_nxt;
    logic                  r_sign;
    logic [ACCSIZE-1:0]    r_mag;
    logic [EW-1:0]         r_exp;
    logic [15:0]           r_data;

    logic                  w_take;
    logic [ACCSIZE-1:0]    w_beat_mag;
    logic [ACCSIZE:0]      w_sum;
    logic                  w_acc_sign;
    logic [ACCSIZE-1:0]    w_acc_mag;

    logic [PW-1:0]         w_lead;
    logic [ACCSIZE+6:0]    w_mext;
    logic [6:0]            w_man_t;
    logic                  w_rnd;
    logic [7:0]            w_man_r;
    logic signed [XW-1:0]  w_exp_raw;
    logic signed [XW-1:0]  w_exp_fin;
    logic [15:0]           w_result;

    assign w_take  = i_valid && r_ready;
    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // State register and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = i_last ? S_NORM : S_ACC;
            S_ACC:   if (w_take && i_last) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_OUT;
            S_OUT:   if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they line up with r_state
    always_comb begin
        w_ready_nxt = 1'b0;
        w_valid_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE, S_ACC: w_ready_nxt = 1'b1;
            S_OUT:         w_valid_nxt = 1'b1;
            default:       w_ready_nxt = 1'b0;
        endcase
    end

    // Sign-magnitude accumulate with saturation
    assign w_beat_mag = ACCSIZE'(i_man);
    assign w_sum      = {1'b0, r_mag} + {1'b0, w_beat_mag};

    always_comb begin
        w_acc_sign = r_sign;
        w_acc_mag  = r_mag;
        if (r_sign == i_sign) begin
            w_acc_mag = w_sum[ACCSIZE] ? {ACCSIZE{1'b1}} : w_sum[ACCSIZE-1:0];
        end else if (r_mag > w_beat_mag) begin
            w_acc_mag = r_mag - w_beat_mag;
        end else if (w_beat_mag > r_mag) begin
            w_acc_sign = i_sign;
            w_acc_mag  = w_beat_mag - r_mag;
        end else begin
            w_acc_sign = 1'b0;
            w_acc_mag  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_exp  <= '0;
            r_data <= '0;
        end else begin
            if (w_take && r_state == S_IDLE) begin
                r_sign <= i_sign;
                r_mag  <= w_beat_mag;
                r_exp  <= i_exp;
            end else if (w_take) begin
                r_sign <= w_acc_sign;
                r_mag  <= w_acc_mag;
            end
            if (r_state == S_NORM) r_data <= w_result;
        end
    end

    // Leading-one position; highest set bit wins
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < ACCSIZE; i++) begin
            if (r_mag[i]) w_lead = PW'(i);
        end
    end

    // The 7 bits below the leading one, zero-padded when the lead is low
    assign w_mext    = {r_mag, 7'b0};
    assign w_man_t   = w_mext[w_lead +: 7];
    assign w_exp_raw = $signed(XW'(r_exp)) - $signed(XW'(MULBFPMANSIZE)) + $signed(XW'(w_lead));

`ifdef FMAC_RNE_EN
    logic [ACCSIZE+7:0] w_rext;
    logic               w_guard;
    logic               w_sticky;
    assign w_rext   = {r_mag, 8'b0};
    assign w_guard  = w_rext[w_lead];
    assign w_sticky = |(r_mag & (((ACCSIZE'(1) << w_lead) - ACCSIZE'(1)) >> 8));
    assign w_rnd    = w_guard & (w_sticky | w_man_t[0]);
`else
    assign w_rnd    = 1'b0;
`endif

    assign w_man_r   = {1'b0, w_man_t} + 8'(w_rnd);
    assign w_exp_fin = w_exp_raw + $signed(XW'(w_man_r[7]));

    always_comb begin
        w_result = {r_sign, w_exp_fin[7:0], w_man_r[6:0]};
        if (r_mag == '0) begin
            w_result = 16'h0000;
        end else if (w_exp_fin >= $signed(XW'(255))) begin
            w_result = {r_sign, 8'hFF, 7'h00};
        end else if (w_exp_fin <= $signed(XW'(0))) begin
            w_result = {r_sign, 15'h0000};
        end
    end

endmodule

// File: doc/bfp_acc_normalizer.md
BFP_ACC_NORMALIZER -- requirements
Module: bfp_acc_normalizer

Interface
REQ-001 SHALL have parameter GRPSIZE, default 16, meaning products per group.
REQ-002 SHALL have parameter MULBFPMANSIZE, default 6, meaning fraction bits (FRAC) of each product magnitude.
REQ-003 SHALL have parameter LEVELS, default $clog2(GRPSIZE), meaning adder-tree depth.
REQ-004 SHALL have parameter BFPEXPSIZE, default 8, meaning the biased exponent width (bias 127).
REQ-005 SHALL have parameter ACCSIZE, default 16, meaning the accumulator magnitude width (>= MULBFPMANSIZE+LEVELS).
REQ-006 Ports (name  direction  width  meaning):
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts an input beat.
- i_sign  in  1  group-sum sign (1 = negative).
- i_man  in  MULBFPMANSIZE+LEVELS  group-sum magnitude.
- i_exp  in  BFPEXPSIZE+1  biased product exponent, sampled on the first beat only.
- i_last  in  1  final group of the dot product.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_data  out  16  bfloat16 result {sign, exp[7:0], man[6:0]}.

Function
REQ-007 An input beat SHALL transfer when i_valid && o_ready; a result SHALL transfer when o_valid && i_ready.
REQ-008 FSM states SHALL be IDLE, ACC, NORM and OUT.
REQ-009 IDLE: o_ready=1; on a beat, load the accumulator with the signed beat and capture i_exp; go to NORM if i_last, else to ACC.
REQ-010 ACC: o_ready=1; on a beat, add the beat to the accumulator; go to NORM if i_last; with no beat, hold state.
REQ-011 NORM: o_ready=0; compute and register o_data; go to OUT after exactly 1 cycle.
REQ-012 OUT: o_ready=0; o_valid=1; o_data stable until i_ready; then go to IDLE, with o_valid=0 in the next cycle.
REQ-013 Latency SHALL be o_valid asserted 2 cycles after the last beat transfers; back-to-back dot products incur a 1-cycle IDLE bubble minimum.
REQ-014 Accumulation SHALL be sign-magnitude: same signs add magnitudes; differing signs subtract the smaller magnitude from the larger, and the result takes the larger operand's sign.
REQ-015 Equal magnitudes with opposite signs SHALL give magnitude 0 with sign 0.
REQ-016 Magnitude overflow past 2^ACCSIZE-1 SHALL saturate to all ones, keeping the sign.
REQ-017 The value represented SHALL be (-1)^s * mag * 2^(E-127-FRAC), where E is the captured i_exp.
REQ-018 Normalization: p = index of the leading one of mag; exponent = E - FRAC + p; mantissa = the 7 bits below the leading one, zero-padded on the right when p < 7.
REQ-019 mag == 0 SHALL give o_data = 16'h0000.
REQ-020 An exponent >= 255 SHALL give signed infinity {s, 8'hFF, 7'h0}.
REQ-021 An exponent <= 0 SHALL flush to {s, 15'h0}.
REQ-022 A beat arriving while in NORM or OUT SHALL NOT be accepted.

Reset
REQ-023 While i_rst=1 at a clock edge, the FSM SHALL go to IDLE and the accumulator and captured exponent SHALL clear.
REQ-024 Reset values SHALL be o_ready=1, o_valid=0 and o_data=0; o_ready rises in the cycle after the reset edge.
REQ-025 Reset in ACC, NORM or OUT SHALL discard the partial sum and any pending result without emitting it.

Configuration
REQ-026 Macro FMAC_RNE_EN SHALL select mantissa rounding.
REQ-027 With FMAC_RNE_EN defined, rounding SHALL be round-to-nearest-even on the bits below the 7-bit mantissa; mantissa carry-out increments the exponent, and that increment is rechecked against REQ-020.
REQ-028 Without FMAC_RNE_EN, the mantissa SHALL be truncated.

Verification
REQ-029 E=127, single beat {s=0, man=64, last=1} -> o_data=16'h3F80, o_valid 2 cycles after the beat.
REQ-030 E=127, beats {0,3},{1,5,last} -> o_data=16'hBD00.
REQ-031 E=127, beats {0,100},{1,100,last} -> o_data=16'h0000.
REQ-032 E=254, single beat {0,1023,last} -> o_data=16'h7F80.
REQ-033 E=127, single beat {0,1023,last} -> o_data=16'h417F without FMAC_RNE_EN, 16'h4180 with FMAC_RNE_EN.
REQ-034 i_ready held 0 for 5 cycles in OUT -> o_data stable and o_ready=0 throughout; i_rst pulsed in ACC -> next dot product result excludes the pre-reset beats.
